pipe_buf_stage: RTL

Parametrised pipeline buffer stage that generalises the fixed IF/ID, ID/EX, EX/MEM and MEM/WB packed-struct registers of the RISC-V core into one reusable block. It carries an opaque WIDTH-bit payload (any packed stage struct cast to bits) with a valid/ready handshake, flush, and an optional two-entry skid mode that registers the upstream ready. It also keeps a saturating back-pressure counter for performance debug. One instance sits between each pair of pipeline stages.

---
 rtl/pipe_buf_stage.sv | 104 ++++++++++
 1 files changed

// File: rtl/pipe_buf_stage.sv
// Reusable pipeline buffer stage: opaque payload with valid/ready, flush,
// an optional two-entry skid mode with registered in_ready, and a stall counter.
module pipe_buf_stage #(
    parameter int WIDTH = 32,
    parameter int SKID  = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             rdy_q, rdy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_fire, out_fire;

    assign out_valid = (state_q != ST_EMPTY);
    // Skid mode cuts the out_ready -> in_ready combinational path.
    assign in_ready  = (SKID != 0) ? rdy_q : (~out_valid | out_ready);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign out_data  = main_q;
    assign occupancy = state_q;
    assign stall_cnt = cnt_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    main_d  = in_data;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_fire && (out_fire || SKID == 0)) begin
                    main_d = in_data;
                end else if (in_fire) begin
                    skid_d  = in_data;
                    state_d = ST_FULL;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        // A redirect wins over both handshakes and drops any offered payload.
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end

        rdy_d = (state_d != ST_FULL);

        if (out_valid && !out_ready && cnt_q != '1)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            rdy_q   <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            rdy_q   <= rdy_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
